clock_display: RTL and testbench
================================

CLOCK_DISPLAY -- requirements
Module: clock_display

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clk cycles per digit slot (1 kHz digit rate at 50 MHz); legal range 4..2^20.
REQ-002 Parameter BLANK_CYC, default 500: cycles at the start of each slot with all digits off (anti-ghosting); legal range 0..SCAN_DIV-2.
REQ-003 clk  input  1  system clock; all registers on rising edge.
REQ-004 rset  input  1  reset; synchronous, active-high.
REQ-005 sec  input  8  binary seconds from the time counter; legal 0..59.
REQ-006 min  input  8  binary minutes; legal 0..59.
REQ-007 hour  input  8  binary hours; legal 0..23.
REQ-008 seg  output  8  active-low segments, seg[6:0]=g,f,e,d,c,b,a, seg[7]=dp.
REQ-009 dig_sel  output  6  active-low one-hot digit enable; bit0 = rightmost digit.

Function
REQ-010 Prescaler pc SHALL count 0..SCAN_DIV-1 and then wrap to 0.
REQ-011 Digit index idx SHALL advance when pc==SCAN_DIV-1: 0,1,2,3,4,5, then wrap to 0.
REQ-012 Digit map: idx0=sec ones, idx1=sec tens, idx2=min ones, idx3=min tens, idx4=hour ones, idx5=hour tens.
REQ-013 Snapshot registers s_sec/s_min/s_hour SHALL load sec/min/hour only on the cycle where pc==SCAN_DIV-1 and idx==5 (frame boundary). A displayed frame therefore never mixes two input values.
REQ-014 Input changes between frame boundaries SHALL have no effect on the outputs.
REQ-015 BCD split per field: tens = value/10 and ones = value mod 10, from the snapshot; implemented without a divider (compare/subtract over range 0..99).
REQ-016 Field validity: sec or min >59, or hour >23, marks that field invalid. Both digits of an invalid field SHALL show dash (seg[6:0]=7'b0111111). Other fields are unaffected.
REQ-017 Digit glyphs 0..9, active-low, g..a:
- 0 = 1000000
- 1 = 1111001
- 2 = 0100100
- 3 = 0110000
- 4 = 0011001
- 5 = 0010010
- 6 = 0000010
- 7 = 1111000
- 8 = 0000000
- 9 = 0010000
REQ-018 No leading-zero blanking; hour tens of 0 SHALL display "0".
REQ-019 Colon dp: seg[7]=0 on idx2 and idx4 when s_sec[0]==0; seg[7]=1 otherwise and on all other digits.
REQ-020 seg and dig_sel SHALL be registered. They are decoded from the current-cycle (idx, pc, snapshot), so the outputs lag those registers by exactly one cycle.
REQ-021 dig_sel per cycle:
- when decoded pc < BLANK_CYC: 6'b111111;
- otherwise: bit idx = 0, all other bits = 1.
REQ-022 seg SHALL be driven with the glyph for idx throughout the slot, including the blank cycles.
REQ-023 At most one dig_sel bit SHALL be low on any cycle.
REQ-024 With BLANK_CYC=0, dig_sel SHALL change digit directly, with no all-off cycle.

Reset
REQ-025 rset high at a rising edge SHALL set:
- pc=0, idx=0;
- s_sec=s_min=s_hour=0;
- seg=8'hFF, dig_sel=6'b111111.
REQ-026 Reset asserted mid-slot or mid-frame SHALL take priority over all counting and loading. The first frame after release displays 00:00:00 until the first frame boundary.
REQ-027 The first output update after rset deasserts reflects pc=0, idx=0.

Verification (bench uses SCAN_DIV=4, BLANK_CYC=1)
REQ-028 Reset release with sec=7, min=8, hour=9 held:
- first 24 cycles: digits idx0..5 show 0, dp low on idx2/idx4 (s_sec=0);
- cycle after first boundary: 07:08:09 glyphs;
- dp on idx2/idx4 high (sec odd).
REQ-029 Scan pattern: dig_sel over one frame is 111111 for 1 cycle, then 111110 for 3 cycles, repeated for bits 1..5. Then the pattern wraps to bit0; exactly 24 cycles per frame.
REQ-030 Tearing: change sec 59->0 and min 59->0 in mid-frame (idx=2). The current frame still shows 59/59; the next frame shows 00/00; no frame shows a mixed value.
REQ-031 Invalid input: hour=24, min=30, sec=45. Displayed: idx5/idx4 dash (0111111), idx3..0 show 3,0,4,5.
REQ-032 Reset mid-frame: assert rset for 1 cycle at idx=3, pc=2. The next cycle gives seg=FF, dig_sel=111111; counting then restarts at idx0 with 00:00:00 shown.

Source files
------------

// File: rtl/clock_display.sv
// Six-digit multiplexed HH:MM:SS seven-segment driver with frame-coherent input snapshots,
// per-slot anti-ghosting blanking and a blinking colon on the dp segment.
module clock_display #(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 500
) (
    input  logic       clk,
    input  logic       rset,
    input  logic [7:0] sec,
    input  logic [7:0] min,
    input  logic [7:0] hour,
    output logic [7:0] seg,
    output logic [5:0] dig_sel
);

    localparam int unsigned   PW     = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PcLast = PW'(SCAN_DIV - 1);
    localparam logic [6:0]    Dash   = 7'b0111111;

    logic [PW-1:0] pc_q, pc_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    s_sec_q, s_sec_d;
    logic [7:0]    s_min_q, s_min_d;
    logic [7:0]    s_hour_q, s_hour_d;
    logic [7:0]    seg_q, seg_d;
    logic [5:0]    dig_sel_q, dig_sel_d;

    logic          pc_wrap;
    logic          frame_end;
    logic [7:0]    sec_bcd, min_bcd, hour_bcd;
    logic          sec_ok, min_ok, hour_ok;
    logic [3:0]    digit;
    logic          digit_ok;
    logic          dp_n;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

    // Repeated compare/subtract; exact for 0..99, out-of-range fields are masked by the dash.
    function automatic logic [7:0] bcd_split(input logic [7:0] v);
        logic [7:0] rem;
        logic [3:0] tens;
        rem  = v;
        tens = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (rem >= 8'd10) begin
                rem  = rem - 8'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, rem[3:0]};
    endfunction

    assign pc_wrap   = (pc_q == PcLast);
    assign frame_end = pc_wrap && (idx_q == 3'd5);

    always_comb begin
        pc_d     = pc_wrap ? '0 : pc_q + 1'b1;
        idx_d    = idx_q;
        if (pc_wrap) begin
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end
        s_sec_d  = frame_end ? sec  : s_sec_q;
        s_min_d  = frame_end ? min  : s_min_q;
        s_hour_d = frame_end ? hour : s_hour_q;
    end

    assign sec_bcd  = bcd_split(s_sec_q);
    assign min_bcd  = bcd_split(s_min_q);
    assign hour_bcd = bcd_split(s_hour_q);
    assign sec_ok   = (s_sec_q  <= 8'd59);
    assign min_ok   = (s_min_q  <= 8'd59);
    assign hour_ok  = (s_hour_q <= 8'd23);

    always_comb begin
        digit    = 4'd0;
        digit_ok = 1'b1;
        case (idx_q)
            3'd0:    begin digit = sec_bcd[3:0];  digit_ok = sec_ok;  end
            3'd1:    begin digit = sec_bcd[7:4];  digit_ok = sec_ok;  end
            3'd2:    begin digit = min_bcd[3:0];  digit_ok = min_ok;  end
            3'd3:    begin digit = min_bcd[7:4];  digit_ok = min_ok;  end
            3'd4:    begin digit = hour_bcd[3:0]; digit_ok = hour_ok; end
            3'd5:    begin digit = hour_bcd[7:4]; digit_ok = hour_ok; end
            default: ;
        endcase
    end

    // Colon dots sit on the minute-ones and hour-ones digits and blink with the seconds LSB.
    assign dp_n = ~(((idx_q == 3'd2) || (idx_q == 3'd4)) && !s_sec_q[0]);

    always_comb begin
        seg_d     = {dp_n, digit_ok ? glyph(digit) : Dash};
        dig_sel_d = 6'b111111;
        if (32'(pc_q) >= BLANK_CYC) begin
            dig_sel_d[idx_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rset) begin
            pc_q      <= '0;
            idx_q     <= 3'd0;
            s_sec_q   <= 8'd0;
            s_min_q   <= 8'd0;
            s_hour_q  <= 8'd0;
            seg_q     <= 8'hFF;
            dig_sel_q <= 6'b111111;
        end else begin
            pc_q      <= pc_d;
            idx_q     <= idx_d;
            s_sec_q   <= s_sec_d;
            s_min_q   <= s_min_d;
            s_hour_q  <= s_hour_d;
            seg_q     <= seg_d;
            dig_sel_q <= dig_sel_d;
        end
    end

    assign seg     = seg_q;
    assign dig_sel = dig_sel_q;

endmodule

// File: tb/tb_clock_display.sv
// Scoreboard bench for clock_display (SCAN_DIV=4, BLANK_CYC=1): stimulus pushes the expected
// seg/dig_sel for every cycle, a negedge monitor pops and compares.
module tb_clock_display;

  localparam int unsigned ScanDiv  = 4;
  localparam int unsigned BlankCyc = 1;
  localparam int          FrameCyc = 6 * ScanDiv;

  logic       clk;
  logic       rset;
  logic [7:0] sec;
  logic [7:0] min;
  logic [7:0] hour;
  logic [7:0] seg;
  logic [5:0] dig_sel;

  typedef struct {
    logic [7:0] seg;
    logic [5:0] dig;
    int         frame;
    int         pos;
  } exp_t;

  exp_t q[$];
  int   tests;
  int   fails;
  int   frame_no;

  clock_display #(
    .SCAN_DIV (ScanDiv),
    .BLANK_CYC(BlankCyc)
  ) dut (
    .clk    (clk),
    .rset   (rset),
    .sec    (sec),
    .min    (min),
    .hour   (hour),
    .seg    (seg),
    .dig_sel(dig_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Digit code 4'hA stands for the dash shown on an invalid field.
  function automatic logic [6:0] ref_glyph(input logic [3:0] c);
    logic [6:0] g;
    case (c)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1111000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0010000;
      4'hA:    g = 7'b0111111;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  task automatic step(input logic [7:0] s, input logic [5:0] d, input int f, input int p);
    exp_t e;
    @(posedge clk);
    #1;
    e.seg   = s;
    e.dig   = d;
    e.frame = f;
    e.pos   = p;
    q.push_back(e);
  endtask

  // disp holds digits idx5..idx0 as nibbles, so 24'h123456 reads as 12:34:56.
  task automatic run_frame(input logic [23:0] disp, input bit dplow, input int change_at,
                           input logic [7:0] ns, input logic [7:0] nm, input logic [7:0] nh,
                           input int rst_at);
    int         d;
    logic [7:0] s;
    logic [5:0] ds;
    for (int p = 0; p < FrameCyc; p++) begin
      if (p == rst_at) begin
        rset = 1'b1;
        step(8'hFF, 6'b111111, frame_no, p);
        rset = 1'b0;
        frame_no++;
        return;
      end
      d      = p / ScanDiv;
      s[6:0] = ref_glyph(disp[d*4 +: 4]);
      s[7]   = (dplow && (d == 2 || d == 4)) ? 1'b0 : 1'b1;
      ds     = 6'b111111;
      if ((p % ScanDiv) >= BlankCyc) ds[d] = 1'b0;
      step(s, ds, frame_no, p);
      if (p == change_at) begin
        sec  = ns;
        min  = nm;
        hour = nh;
      end
    end
    frame_no++;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      tests++;
      if (seg !== e.seg || dig_sel !== e.dig) begin
        fails++;
        $display("FAIL frame%0d_pos%0d: got seg=%b dig_sel=%b, want seg=%b dig_sel=%b",
                 e.frame, e.pos, seg, dig_sel, e.seg, e.dig);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    tests    = 0;
    fails    = 0;
    frame_no = 0;
    rset     = 1'b1;
    sec      = 8'd7;
    min      = 8'd8;
    hour     = 8'd9;

    step(8'hFF, 6'b111111, -1, 0);
    step(8'hFF, 6'b111111, -1, 1);
    tests++;
    if (seg !== 8'hFF) begin
      fails++;
      $display("FAIL reset_seg: got seg=%b, want 11111111", seg);
    end
    tests++;
    if (dig_sel !== 6'b111111) begin
      fails++;
      $display("FAIL reset_dig_sel: got dig_sel=%b, want 111111", dig_sel);
    end
    rset = 1'b0;

    // Post-reset frame shows zeros; 7/8/9 appear only after the first boundary.
    run_frame(24'h000000, 1'b1, -1, 8'd0, 8'd0, 8'd0, -1);
    run_frame(24'h090807, 1'b0, 10, 8'd59, 8'd59, 8'd23, -1);
    // Tearing: 59->0 changes mid-frame must not reach this frame.
    run_frame(24'h235959, 1'b0, 10, 8'd0, 8'd0, 8'd23, -1);
    run_frame(24'h230000, 1'b1, 10, 8'd45, 8'd30, 8'd24, -1);
    // Invalid fields: hour=24, then sec=60, then min=60.
    run_frame(24'hAA3045, 1'b0, 10, 8'd60, 8'd5, 8'd0, -1);
    run_frame(24'h0005AA, 1'b1, 10, 8'd58, 8'd60, 8'd10, -1);
    run_frame(24'h10AA58, 1'b1, 10, 8'd56, 8'd34, 8'd12, -1);
    // One-cycle reset at idx3/pc2, then a fresh zero frame before 12:34:56 returns.
    run_frame(24'h123456, 1'b1, -1, 8'd0, 8'd0, 8'd0, 14);
    run_frame(24'h000000, 1'b1, -1, 8'd0, 8'd0, 8'd0, -1);
    run_frame(24'h123456, 1'b1, -1, 8'd0, 8'd0, 8'd0, -1);

    @(negedge clk);
    @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d expectations left unchecked", q.size());
    end
    tests++;
    if (tests < 12) begin
      fails++;
      $display("FAIL check_count: only %0d checks ran", tests);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
